// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection; captures decode state one clock after presentation.
// ex_hold freezes the stage and flush inserts a bubble; a load-use hazard costs exactly one bubble and is counted.
module id_ex_pipeline_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [14:0] id_ctrl,
   input  logic [6:0]  id_opcode,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic [3:0]  id_funct,
   input  logic        ex_hold,
   input  logic        flush,
   output logic        ex_valid,
   output logic [14:0] ex_ctrl,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [4:0]  ex_rd,
   output logic [3:0]  ex_funct,
   output logic        id_stall,
   output logic [15:0] stall_count
);

   typedef struct packed {
      logic [14:0] ctrl;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
   } ex_dat_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic        r_valid;
   ex_dat_t     r_ex;
   logic [15:0] r_stall_count;

   ex_dat_t     w_id_dat;
   logic        w_use_rs1;
   logic        w_use_rs2;
   logic        w_hazard;

   assign w_id_dat = '{ctrl: id_ctrl, pc: id_pc, rs1_data: id_rs1_data,
                       rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1,
                       rs2: id_rs2, rd: id_rd, funct: id_funct};

   assign w_use_rs1 = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign w_use_rs2 = id_opcode inside {OP_RTYPE, OP_STORE, OP_BRANCH};

   // ctrl[10] is MemRead: only a load in EX can create a load-use hazard
   assign w_hazard = r_valid & r_ex.ctrl[10] & (r_ex.rd != 5'd0) & id_valid &
                     ((w_use_rs1 & (id_rs1 == r_ex.rd)) |
                      (w_use_rs2 & (id_rs2 == r_ex.rd)));

   assign id_stall = (w_hazard | ex_hold) & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_ex          <= '0;
         r_stall_count <= 16'd0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ex    <= '0;
      end else if (ex_hold) begin
         r_valid <= r_valid;
         r_ex    <= r_ex;
      end else if (w_hazard) begin
         r_valid <= 1'b0;
         r_ex    <= '0;
         if (r_stall_count != 16'hFFFF)
            r_stall_count <= r_stall_count + 16'd1;
      end else if (id_valid) begin
         r_valid <= 1'b1;
         r_ex    <= w_id_dat;
      end else begin
         r_valid <= 1'b0;
         r_ex    <= '0;
      end
   end

   assign ex_valid    = r_valid;
   assign ex_ctrl     = r_ex.ctrl;
   assign ex_pc       = r_ex.pc;
   assign ex_rs1_data = r_ex.rs1_data;
   assign ex_rs2_data = r_ex.rs2_data;
   assign ex_imm      = r_ex.imm;
   assign ex_rs1      = r_ex.rs1;
   assign ex_rs2      = r_ex.rs2;
   assign ex_rd       = r_ex.rd;
   assign ex_funct    = r_ex.funct;
   assign stall_count = r_stall_count;

endmodule
